// File: rtl/im_boot_ctrl.sv
// Purpose: boot loader that packs a big-endian byte stream into 32-bit words and writes them to the IM from address 0, holding the CPU stalled until the load ends.
// Latency: a word's write strobe appears one cycle after its 4th byte is accepted; a partial tail word is written in the cycle after the FLUSH state.
// Backpressure: in_ready is high for the whole LOAD state, so throughput is 1 byte/cycle; it is low in all other states.
module im_boot_ctrl #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  boot_req,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  im_we,
  output logic [DEPTH_LOG2-1:0] im_waddr,
  output logic [31:0]           im_wdata,
  output logic                  cpu_hold,
  output logic                  cpu_start,
  output logic [DEPTH_LOG2:0]   word_count,
  output logic                  err_overflow,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  // Word count at which the IM is full; further completions are dropped.
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ONE_CNT  = {{DEPTH_LOG2{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [1:0]            bcnt_q, bcnt_d;
  // Only the three most recent bytes are kept; the 4th comes straight from in_data.
  logic [23:0]           asm_q, asm_d;
  logic [DEPTH_LOG2:0]   wcnt_q, wcnt_d;
  logic                  err_q, err_d;
  logic                  we_q, we_d;
  logic [DEPTH_LOG2-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  rdy_q, rdy_d;
  logic                  hold_q, hold_d;
  logic                  start_q, start_d;

  logic                  accept;
  logic                  commit;
  logic [31:0]           commit_word;
  logic [31:0]           pad_word;

  assign accept = in_valid & rdy_q & (state_q == S_LOAD);

  // Left-justify whatever bytes are pending and zero-fill the rest.
  always_comb begin
    pad_word = 32'h0;
    case (bcnt_q)
      2'd1:    pad_word = {asm_q[7:0], 24'h0};
      2'd2:    pad_word = {asm_q[15:0], 16'h0};
      2'd3:    pad_word = {asm_q[23:0], 8'h0};
      default: pad_word = 32'h0;
    endcase
  end

  // Next-state, byte assembly and write scheduling.
  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    asm_d       = asm_q;
    wcnt_d      = wcnt_q;
    err_d       = err_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    commit      = 1'b0;
    commit_word = 32'h0;

    case (state_q)
      S_IDLE: begin
        if (boot_req) begin
          state_d = S_LOAD;
          wcnt_d  = '0;
          bcnt_d  = 2'd0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        // boot_req is deliberately ignored here; a load runs to in_last.
        if (accept) begin
          asm_d  = {asm_q[15:0], in_data};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            commit      = 1'b1;
            commit_word = {asm_q, in_data};
          end
          if (in_last) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (bcnt_q != 2'd0) begin
          commit      = 1'b1;
          commit_word = pad_word;
        end
        bcnt_d  = 2'd0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (boot_req) begin
          state_d = S_LOAD;
          wcnt_d  = '0;
          bcnt_d  = 2'd0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A completed word either lands in the IM or, once it is full, only flags overflow.
    if (commit) begin
      if (wcnt_q == FULL_CNT) begin
        err_d = 1'b1;
      end else begin
        we_d    = 1'b1;
        waddr_d = wcnt_q[DEPTH_LOG2-1:0];
        wdata_d = commit_word;
        wcnt_d  = wcnt_q + ONE_CNT;
      end
    end

    // Handshake and CPU controls are derived from the state being entered so they are registered.
    rdy_d   = (state_d == S_LOAD);
    hold_d  = (state_d != S_RUN);
    start_d = (state_d == S_RUN) && (state_q != S_RUN);
  end

  // State and output registers; reset discards any write scheduled for the next cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      bcnt_q  <= 2'd0;
      asm_q   <= 24'h0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= 32'h0;
      rdy_q   <= 1'b0;
      hold_q  <= 1'b1;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
      hold_q  <= hold_d;
      start_q <= start_d;
    end
  end

  assign in_ready     = rdy_q;
  assign im_we        = we_q;
  assign im_waddr     = waddr_q;
  assign im_wdata     = wdata_q;
  assign cpu_hold     = hold_q;
  assign cpu_start    = start_q;
  assign word_count   = wcnt_q;
  assign err_overflow = err_q;
  assign state        = state_q;

endmodule

// File: doc/im_boot_ctrl.md
# im_boot_ctrl

Boot/load controller for the 1024-word instruction memory. It receives a program as a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes them through the instruction memory's write port at consecutive word addresses from 0, holding the CPU stalled for the whole load. When the stream ends it releases the CPU with a one-cycle start pulse. It sits between the host/debug link and the IM write port, alongside the CPU's fetch path.

## Interface
- DEPTH_LOG2, 10, IM word-address width (1024 words)
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- boot_req  input  1  request to (re)load IM; honoured in IDLE and RUN only
- in_valid  input  1  byte available on in_data
- in_data  input  8  program byte, most-significant byte of each word first
- in_last  input  1  qualifies the final byte of the stream
- in_ready  output  1  controller accepts a byte this cycle
- im_we  output  1  IM write strobe, one cycle per word
- im_waddr  output  DEPTH_LOG2  IM word address
- im_wdata  output  32  IM write data
- cpu_hold  output  1  stall CPU (PC frozen, no register/memory writes)
- cpu_start  output  1  one-cycle pulse on entering RUN; CPU reloads its reset PC
- word_count  output  DEPTH_LOG2+1  words written in current load (0..1024)
- err_overflow  output  1  sticky: stream exceeded IM depth
- state  output  2  IDLE=0, LOAD=1, FLUSH=2, RUN=3

## Operation
- Reset values (reset low at an edge): state=IDLE, in_ready=0, im_we=0, im_waddr=0, im_wdata=0, cpu_hold=1, cpu_start=0, word_count=0, err_overflow=0, internal byte counter=0, assembly register=0. IM contents are not touched.
- IDLE: cpu_hold=1, in_ready=0. boot_req=1 -> LOAD.
- Entering LOAD from any state: word_count, byte counter and err_overflow are cleared and cpu_hold=1.
- LOAD: in_ready=1. Each accepted byte (in_valid & in_ready) shifts into the assembly register: asm <= {asm[23:0], in_data}. The byte counter increments modulo 4. Cycles with in_valid=0 change nothing.
- Word completion (4th byte accepted): im_wdata={asm[23:0],in_data}, im_waddr=word_count[DEPTH_LOG2-1:0], im_we=1, and word_count increments.
- Overflow: if word_count==1024 at a completion, the write is suppressed (im_we stays 0), word_count holds, and err_overflow is set. Bytes keep being accepted and discarded until in_last.
- An accepted byte with in_last=1 -> FLUSH. That byte is still processed as above.
- FLUSH, one cycle, in_ready=0:
  - If the byte counter is nonzero, the partial word is written left-justified and zero-padded (e.g. 2 bytes AB CD -> ABCD0000), word_count increments, and the overflow rule applies.
  - The byte counter clears. Then -> RUN.
- RUN: cpu_hold=0, in_ready=0. cpu_start=1 only in the first RUN cycle. boot_req=1 -> LOAD.
- boot_req is ignored in LOAD and FLUSH.
- A stream with in_last on a word boundary produces no FLUSH write.

## Timing
- All outputs are registered.
- im_we is asserted in the cycle after the completing byte's acceptance edge and lasts exactly one cycle. Address and data are stable with it.
- Sustained throughput is 1 byte/cycle, i.e. one word write every 4 cycles.
- in_ready rises in the first LOAD cycle, one cycle after boot_req is sampled. It falls in the cycle after the in_last byte is accepted.
- FLUSH lasts exactly 1 cycle. The partial-word im_we coincides with state=RUN's predecessor cycle being FLUSH, i.e. the pulse is visible in the RUN entry cycle.
- cpu_hold falls and cpu_start rises in the same cycle, the first RUN cycle.
- From boot_req in RUN, cpu_hold rises on the next cycle.
- Reset low mid-operation overrides everything at the next edge. No pending write is issued.
- Simultaneous boot_req and reset low: reset wins.

## Test plan
- Reset, boot_req, stream 34 01 00 01 00 41 10 20 with in_last on the last byte -> writes addr0=34010001 and addr1=00411020. word_count=2, no FLUSH write, then one cpu_start pulse with cpu_hold=0.
- Stream AA BB CC DD 11 22 with last -> addr0=AABBCCDD, then the FLUSH write addr1=11220000. word_count=2.
- Same 8-byte stream with in_valid low on alternate cycles -> identical writes, with im_we pulses separated by ≥7 cycles.
- Stream 1025 words + last -> exactly 1024 writes, last at addr 1023. err_overflow=1 and word_count=1024.
- Reset low after 3 accepted bytes -> all outputs at reset values next cycle. A new boot then writes its first word to addr 0.
- In RUN, boot_req -> cpu_hold=1 and word_count=0 next cycle. boot_req pulsed during LOAD has no effect.
